sevenseg_scan_mux: RTL and testbench



---
 rtl/sevenseg_scan_mux_if.sv | 28 ++
 rtl/sevenseg_scan_mux.sv | 128 ++++++++++++
 tb/tb_sevenseg_scan_mux.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_mux_if.sv
// Bundle between a scan controller and its host / display driver.
// Latency: none (wires only).
// Backpressure: none; load is a fire-and-forget strobe.
//
// master: host side (drives the frame data, observes the display outputs)
// slave : scan controller side
interface sevenseg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;        // single-cycle capture strobe
    logic [4*NUM_DIGITS-1:0]   digits_in;   // packed BCD, digit i = [4i+3:4i]
    logic [NUM_DIGITS-1:0]     dp_in;       // decimal point per digit
    logic                      blank_lz;    // suppress leading zeros (live)
    logic [3:0]                number;      // code of scanned digit
    logic [NUM_DIGITS-1:0]     digit_en;    // one-hot digit enables
    logic                      dp;          // decimal point of scanned digit
    logic                      frame_done;  // pulse at each frame wrap

    modport master (
        output load, digits_in, dp_in, blank_lz,
        input  number, digit_en, dp, frame_done
    );

    modport slave (
        input  load, digits_in, dp_in, blank_lz,
        output number, digit_en, dp, frame_done
    );
endinterface

// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed 7-segment scan controller with blanking, leading-zero suppression and tear-free frame updates.
// Latency: a load becomes visible at the next frame wrap (same wrap if loaded on the boundary cycle).
// Backpressure: none; loads are always accepted, a later load in the same frame overwrites the pending one.
//
// Ports: clk, rst_n (synchronous, active low); bus (slave modport) carries
// load/digits_in/dp_in/blank_lz in and number/digit_en/dp/frame_done out.
module sevenseg_scan_mux #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int BLANK_CYCLES     = 500,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    sevenseg_scan_mux_if.slave  bus
);
    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [SW-1:0]            slot_cnt;
    logic [IW-1:0]            idx;
    logic [4*NUM_DIGITS-1:0]  active_dig;
    logic [NUM_DIGITS-1:0]    active_dp;
    logic [4*NUM_DIGITS-1:0]  pend_dig;
    logic [NUM_DIGITS-1:0]    pend_dp;
    logic                     pend_vld;
    logic                     frame_done_q;

    logic                     slot_last;
    logic                     frame_wrap;

    assign slot_last  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_last && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt     <= '0;
            idx          <= '0;
            active_dig   <= '0;
            active_dp    <= '0;
            pend_dig     <= '0;
            pend_dp      <= '0;
            pend_vld     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // Registered so the pulse lines up with idx==0, slot_cnt==0.
            frame_done_q <= frame_wrap;

            if (slot_last) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end

            // Active contents only change on the frame wrap so a frame is
            // never displayed half old, half new. A load on the wrap cycle
            // itself is the newest data and bypasses the pending stage.
            if (frame_wrap && bus.load) begin
                active_dig <= bus.digits_in;
                active_dp  <= bus.dp_in;
                pend_vld   <= 1'b0;
            end else if (frame_wrap && pend_vld) begin
                active_dig <= pend_dig;
                active_dp  <= pend_dp;
                pend_vld   <= 1'b0;
            end else if (bus.load) begin
                pend_dig   <= bus.digits_in;
                pend_dp    <= bus.dp_in;
                pend_vld   <= 1'b1;
            end
        end
    end

    // Leading-zero suppression: walk down from the top digit while every
    // digit seen so far is zero. Digit 0 is never suppressed. Codes 10-15
    // compare as non-zero and so stop the run.
    logic [NUM_DIGITS-1:0] supp;
    logic                  zero_run;

    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run & (active_dig[4*i +: 4] == 4'd0);
            supp[i]  = bus.blank_lz & zero_run;
        end
    end

    logic [3:0]            cur_dig;
    logic                  cur_dp;
    logic                  cur_supp;
    logic                  en_win;
    logic [NUM_DIGITS-1:0] en_oh;

    always_comb begin
        cur_dig  = '0;
        cur_dp   = 1'b0;
        cur_supp = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_dig  = active_dig[4*i +: 4];
                cur_dp   = active_dp[i];
                cur_supp = supp[i];
            end
        end
    end

    // Enable window opens after the anti-ghosting blank period.
    assign en_win = (slot_cnt >= BLANK_END) && !cur_supp;

    always_comb begin
        en_oh = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                en_oh[i] = en_win;
            end
        end
    end

    assign bus.number     = cur_dig;
    assign bus.dp         = cur_dp & en_win;
    assign bus.digit_en   = (DIGIT_ACTIVE_LOW != 0) ? ~en_oh : en_oh;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Directed, table-driven bench for sevenseg_scan_mux with a 4-digit,
// 8-cycle slot, 2-cycle blank, active-low enable configuration.
// One frame = 32 cycles; cyc counts rising edges since reset release.
module tb_sevenseg_scan_mux;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    sevenseg_scan_mux_if #(.NUM_DIGITS(4)) bus ();

    sevenseg_scan_mux #(
        .NUM_DIGITS       (4),
        .REFRESH_DIV      (8),
        .BLANK_CYCLES     (2),
        .DIGIT_ACTIVE_LOW (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [3:0] num;
        logic [3:0] en;
        logic       dp;
        logic       fd;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int off);
        for (int k = 0; k < 32; k++) begin
            if ((cyc % 32) == off) break;
            step();
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        bus.load      = 1'b1;
        bus.digits_in = d;
        bus.dp_in     = p;
        step();
        bus.load      = 1'b0;
    endtask

    // Must be called at frame offset 0; returns at offset 31 of the same frame.
    task automatic scan_frame(input string name, input logic [15:0] digs,
                              input logic [3:0] lit, input logic [3:0] dpx,
                              input logic exp_fd);
        logic [3:0] en_exp;
        check({name, " fd@0"}, {15'd0, bus.frame_done}, {15'd0, exp_fd});
        for (int i = 0; i < 4; i++) begin
            en_exp = lit[i] ? ~(4'b0001 << i) : 4'b1111;
            goto(8*i + 1);
            check({name, " blank num"}, {12'd0, bus.number},   {12'd0, digs[4*i +: 4]});
            check({name, " blank en"},  {12'd0, bus.digit_en}, 16'h000f);
            check({name, " blank dp"},  {15'd0, bus.dp},       16'h0000);
            goto(8*i + 4);
            check({name, " num"},       {12'd0, bus.number},   {12'd0, digs[4*i +: 4]});
            check({name, " en"},        {12'd0, bus.digit_en}, {12'd0, en_exp});
            check({name, " dp"},        {15'd0, bus.dp},       {15'd0, dpx[i] & lit[i]});
            goto(8*i + 7);
            check({name, " en end"},    {12'd0, bus.digit_en}, {12'd0, en_exp});
        end
    endtask

    initial begin
        logic [3:0] en1;
        checks   = 0;
        failures = 0;
        cyc      = 0;

        tbl[0]  = '{0,  4'd4, 4'b1111, 1'b0, 1'b1};
        tbl[1]  = '{1,  4'd4, 4'b1111, 1'b0, 1'b0};
        tbl[2]  = '{2,  4'd4, 4'b1110, 1'b0, 1'b0};
        tbl[3]  = '{7,  4'd4, 4'b1110, 1'b0, 1'b0};
        tbl[4]  = '{8,  4'd3, 4'b1111, 1'b0, 1'b0};
        tbl[5]  = '{10, 4'd3, 4'b1101, 1'b0, 1'b0};
        tbl[6]  = '{16, 4'd2, 4'b1111, 1'b0, 1'b0};
        tbl[7]  = '{18, 4'd2, 4'b1011, 1'b1, 1'b0};
        tbl[8]  = '{23, 4'd2, 4'b1011, 1'b1, 1'b0};
        tbl[9]  = '{24, 4'd1, 4'b1111, 1'b0, 1'b0};
        tbl[10] = '{26, 4'd1, 4'b0111, 1'b0, 1'b0};
        tbl[11] = '{31, 4'd1, 4'b0111, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.dp_in     = '0;
        bus.blank_lz  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst number", {12'd0, bus.number},   16'h0000);
        check("rst en",     {12'd0, bus.digit_en}, 16'h000f);
        check("rst dp",     {15'd0, bus.dp},       16'h0000);
        check("rst fd",     {15'd0, bus.frame_done}, 16'h0000);
        rst_n = 1'b1;
        cyc   = 0;

        // Idle scan after reset: digit 0 shown everywhere, blank_lz off.
        for (int c = 0; c <= 32; c++) begin
            en1 = ((c % 8) < 2) ? 4'b1111 : ~(4'b0001 << ((c / 8) % 4));
            check("idle num", {12'd0, bus.number},   16'h0000);
            check("idle en",  {12'd0, bus.digit_en}, {12'd0, en1});
            check("idle fd",  {15'd0, bus.frame_done}, {15'd0, (c == 32)});
            if (c < 32) step();
        end

        // Mid-frame load must not tear the current frame.
        goto(10);
        do_load(16'h1234, 4'b0100);
        goto(12);
        check("hold num@12", {12'd0, bus.number}, 16'h0000);
        goto(20);
        check("hold num@20", {12'd0, bus.number}, 16'h0000);
        check("hold dp@20",  {15'd0, bus.dp},     16'h0000);
        goto(31);
        check("hold num@31", {12'd0, bus.number}, 16'h0000);
        step();

        for (int v = 0; v < 12; v++) begin
            goto(tbl[v].t);
            check("tbl num", {12'd0, bus.number},     {12'd0, tbl[v].num});
            check("tbl en",  {12'd0, bus.digit_en},   {12'd0, tbl[v].en});
            check("tbl dp",  {15'd0, bus.dp},         {15'd0, tbl[v].dp});
            check("tbl fd",  {15'd0, bus.frame_done}, {15'd0, tbl[v].fd});
        end

        // Two loads in one frame: the latest wins.
        goto(5);
        do_load(16'h1111, 4'b0000);
        goto(20);
        do_load(16'h5678, 4'b0000);
        goto(22);
        check("2load old num", {12'd0, bus.number}, 16'h0002);
        goto(0);
        scan_frame("latest", 16'h5678, 4'b1111, 4'b0000, 1'b1);

        // Leading-zero suppression.
        bus.blank_lz = 1'b1;
        goto(3);
        do_load(16'h0050, 4'b0000);
        goto(0);
        scan_frame("lz0050", 16'h0050, 4'b0011, 4'b0000, 1'b1);
        goto(3);
        do_load(16'h0000, 4'b0000);
        goto(0);
        scan_frame("lz0000", 16'h0000, 4'b0001, 4'b0000, 1'b1);
        goto(3);
        do_load(16'h0A00, 4'b1100);
        goto(0);
        scan_frame("lz0A00", 16'h0A00, 4'b0111, 4'b1100, 1'b1);

        // Load on the boundary cycle bypasses straight to active.
        bus.blank_lz = 1'b0;
        goto(31);
        do_load(16'h9999, 4'b1111);
        scan_frame("bypass", 16'h9999, 4'b1111, 4'b1111, 1'b1);

        // Reset mid-frame with a pending load outstanding.
        goto(3);
        do_load(16'h4321, 4'b0000);
        goto(21);
        rst_n = 1'b0;
        step();
        cyc = 0;
        check("midrst num", {12'd0, bus.number},   16'h0000);
        check("midrst en",  {12'd0, bus.digit_en}, 16'h000f);
        check("midrst dp",  {15'd0, bus.dp},       16'h0000);
        check("midrst fd",  {15'd0, bus.frame_done}, 16'h0000);
        rst_n = 1'b1;
        scan_frame("postrst", 16'h0000, 4'b1111, 4'b0000, 1'b0);
        goto(0);
        scan_frame("nopend", 16'h0000, 4'b1111, 4'b0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
